// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets, STATUS bit
// positions and the default I/O window base.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;
  localparam int          IRQ_W             = 3;

  // Word offsets, i.e. Address[5:2]
  localparam logic [3:0] OFF_PORT_OUT  = 4'h0;
  localparam logic [3:0] OFF_PORT_IN   = 4'h1;
  localparam logic [3:0] OFF_STATUS    = 4'h2;
  localparam logic [3:0] OFF_IRQ_EN    = 4'h3;
  localparam logic [3:0] OFF_TIMER     = 4'h4;
  localparam logic [3:0] OFF_TIMER_CMP = 4'h5;

  localparam int ST_RISE  = 0;
  localparam int ST_FALL  = 1;
  localparam int ST_MATCH = 2;

endpackage

// File: rtl/mmio_input_sync.sv
// Two-flop synchronizer for asynchronous PortIn plus a history flop used to
// detect any-bit rising and falling edges on the synchronized value.
module mmio_input_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic         rise_any,
  output logic         fall_any
);

  logic [W-1:0] meta;
  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise_any = |(sync & ~prev);
  assign fall_any = |(~sync & prev);

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder on the MEM-stage data port: PORT_OUT latch,
// synchronized PORT_IN with sticky edge flags, IRQ mask and, when MMIO_TIMER_EN
// is defined, a free-running timer with compare match.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          IN_WIDTH  = 8,
  parameter logic [31:0] OUT_RESET = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  logic [3:0]          offset;
  logic                wr_en;
  logic [IN_WIDTH-1:0] in_sync;
  logic                rise_any;
  logic                fall_any;
  logic                match_evt;
  logic [IRQ_W-1:0]    status;
  logic [IRQ_W-1:0]    status_set;
  logic [IRQ_W-1:0]    status_clr;
  logic [IRQ_W-1:0]    irq_en;
  logic [31:0]         port_in_ext;
  logic [31:0]         timer_val;
  logic [31:0]         timer_cmp_val;
  logic                unused_addr_lsb;

  assign Hit             = (Address[31:6] == BASE_ADDR[31:6]);
  assign offset          = Address[5:2];
  assign wr_en           = MemWrite && Hit;
  assign unused_addr_lsb = ^Address[1:0];

  mmio_input_sync #(.W(IN_WIDTH)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .din      (PortIn),
    .sync     (in_sync),
    .rise_any (rise_any),
    .fall_any (fall_any)
  );

  always_comb begin
    port_in_ext = '0;
    port_in_ext[IN_WIDTH-1:0] = in_sync;
  end

  always_comb begin
    status_set           = '0;
    status_set[ST_RISE]  = rise_any;
    status_set[ST_FALL]  = fall_any;
    status_set[ST_MATCH] = match_evt;
    status_clr = (wr_en && offset == OFF_STATUS) ? WriteData[IRQ_W-1:0] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PortOut <= OUT_RESET;
      status  <= '0;
      irq_en  <= '0;
    end else begin
      // A set event in the same cycle as a W1C keeps the flag
      status <= (status & ~status_clr) | status_set;
      if (wr_en && offset == OFF_PORT_OUT) PortOut <= WriteData;
      if (wr_en && offset == OFF_IRQ_EN)   irq_en  <= WriteData[IRQ_W-1:0];
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer;
  logic [31:0] timer_cmp;

  // Compare uses the pre-increment value; a bus load replaces that cycle's increment
  assign match_evt = (timer == timer_cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      timer_cmp <= 32'hFFFF_FFFF;
    end else begin
      timer <= (wr_en && offset == OFF_TIMER) ? WriteData : timer + 32'd1;
      if (wr_en && offset == OFF_TIMER_CMP) timer_cmp <= WriteData;
    end
  end

  assign timer_val     = timer;
  assign timer_cmp_val = timer_cmp;
`else
  assign match_evt     = 1'b0;
  assign timer_val     = '0;
  assign timer_cmp_val = '0;
`endif

  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      case (offset)
        OFF_PORT_OUT:  ReadData = PortOut;
        OFF_PORT_IN:   ReadData = port_in_ext;
        OFF_STATUS:    ReadData = {{(32-IRQ_W){1'b0}}, status};
        OFF_IRQ_EN:    ReadData = {{(32-IRQ_W){1'b0}}, irq_en};
        OFF_TIMER:     ReadData = timer_val;
        OFF_TIMER_CMP: ReadData = timer_cmp_val;
        default:       ReadData = '0;
      endcase
    end
  end

  assign Irq = |(status & irq_en);

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed self-checking bench for mmio_port_responder; timer checks follow
// whether MMIO_TIMER_EN is defined for the build.
module tb_mmio_port_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;

  int passed = 0;
  int total  = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  mmio_port_responder dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .Irq       (Irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    step(1);
    MemWrite  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    Address = addr;
    MemRead = 1'b1;
    #1;
    data    = ReadData;
    MemRead = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; Address = 32'h0; WriteData = 32'h0;
    MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
    step(2);
    chk("reset_portout", PortOut, 32'h0);
    chk("reset_irq", {31'b0, Irq}, 32'h0);
    reset = 1'b0;
    step(1);

    // Write/readback of PORT_OUT
    bus_write(32'hFFFF_0000, 32'h1234_5678);
    chk("portout_val", PortOut, 32'h1234_5678);
    bus_read(32'hFFFF_0000, rd);
    chk("portout_read", rd, 32'h1234_5678);
    chk("hit_window", {31'b0, Hit}, 32'h1);
    bus_read(32'hFFFF_0003, rd);
    chk("addr_lsb_ignored", rd, 32'h1234_5678);

    // Simultaneous read+write returns the pre-write value
    Address = 32'hFFFF_0000; WriteData = 32'hCAFE_0001;
    MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    chk("rw_pre_value", ReadData, 32'h1234_5678);
    step(1);
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("rw_commit", PortOut, 32'hCAFE_0001);

    // PortIn rise: PORT_IN after 2 edges, RISE after 3
    PortIn = 8'h81;
    step(1);
    bus_read(32'hFFFF_0004, rd);
    chk("port_in_1edge", rd, 32'h0);
    step(1);
    bus_read(32'hFFFF_0004, rd);
    chk("port_in_2edge", rd, 32'h81);
    bus_read(32'hFFFF_0008, rd);
    chk("status_2edge", rd, 32'h0);
    step(1);
    bus_read(32'hFFFF_0008, rd);
    chk("status_rise", rd, 32'h1);
    bus_write(32'hFFFF_0008, 32'h1);
    bus_read(32'hFFFF_0008, rd);
    chk("status_w1c", rd, 32'h0);

    // Fall with IRQ_EN[1], then W1C racing a fresh fall event
    bus_write(32'hFFFF_000C, 32'h2);
    bus_read(32'hFFFF_000C, rd);
    chk("irq_en_read", rd, 32'h2);
    PortIn = 8'h01;
    step(3);
    bus_read(32'hFFFF_0008, rd);
    chk("status_fall", rd, 32'h2);
    chk("irq_fall", {31'b0, Irq}, 32'h1);
    PortIn = 8'h00;
    step(2);
    bus_write(32'hFFFF_0008, 32'h2);
    bus_read(32'hFFFF_0008, rd);
    chk("w1c_set_wins", rd, 32'h2);
    chk("irq_set_wins", {31'b0, Irq}, 32'h1);
    bus_write(32'hFFFF_0008, 32'h2);
    bus_read(32'hFFFF_0008, rd);
    chk("w1c_clear", rd, 32'h0);
    chk("irq_cleared", {31'b0, Irq}, 32'h0);

    // Outside the window and unused offsets
    Address = 32'h1001_0000; WriteData = 32'hFFFF_FFFF;
    MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    chk("miss_hit", {31'b0, Hit}, 32'h0);
    chk("miss_read", ReadData, 32'h0);
    step(1);
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("miss_no_write", PortOut, 32'hCAFE_0001);
    bus_write(32'hFFFF_0020, 32'hDEAD_BEEF);
    bus_read(32'hFFFF_0020, rd);
    chk("unused_read", rd, 32'h0);
    bus_write(32'hFFFF_0004, 32'h0000_00FF);
    bus_read(32'hFFFF_0004, rd);
    chk("port_in_ro", rd, 32'h0);

`ifdef MMIO_TIMER_EN
    bus_write(32'hFFFF_000C, 32'h4);
    bus_write(32'hFFFF_0014, 32'hFFFF_FFFF);
    bus_write(32'hFFFF_0010, 32'hFFFF_FFFE);
    bus_read(32'hFFFF_0010, rd);
    chk("timer_load", rd, 32'hFFFF_FFFE);
    step(1);
    bus_read(32'hFFFF_0010, rd);
    chk("timer_ff", rd, 32'hFFFF_FFFF);
    bus_read(32'hFFFF_0008, rd);
    chk("match_not_yet", rd, 32'h0);
    step(1);
    bus_read(32'hFFFF_0010, rd);
    chk("timer_wrap", rd, 32'h0);
    bus_read(32'hFFFF_0008, rd);
    chk("match_set", rd, 32'h4);
    chk("irq_match", {31'b0, Irq}, 32'h1);
    bus_write(32'hFFFF_0008, 32'h4);
    bus_write(32'hFFFF_000C, 32'h0);
`else
    bus_write(32'hFFFF_0010, 32'h0000_0055);
    bus_read(32'hFFFF_0010, rd);
    chk("timer_absent", rd, 32'h0);
    bus_write(32'hFFFF_0014, 32'h0000_0055);
    bus_read(32'hFFFF_0014, rd);
    chk("timer_cmp_absent", rd, 32'h0);
`endif

    // Mid-cycle async reset with live state and a pending write
    bus_write(32'hFFFF_0000, 32'h0000_00A5);
    bus_write(32'hFFFF_000C, 32'h3);
    PortIn = 8'h80;
    step(3);
    PortIn = 8'h00;
    step(3);
    bus_read(32'hFFFF_0008, rd);
    chk("pre_reset_status", rd, 32'h3);
    chk("pre_reset_irq", {31'b0, Irq}, 32'h1);
    chk("pre_reset_portout", PortOut, 32'h0000_00A5);
    Address = 32'hFFFF_0000; WriteData = 32'hDEAD_0000; MemWrite = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_irq", {31'b0, Irq}, 32'h0);
    bus_read(32'hFFFF_0008, rd);
    chk("rst_status", rd, 32'h0);
    step(1);
    MemWrite = 1'b0;
    reset = 1'b0;
    step(2);
    chk("post_rst_portout", PortOut, 32'h0);
    chk("post_rst_irq", {31'b0, Irq}, 32'h0);
    bus_read(32'hFFFF_0008, rd);
    chk("post_rst_status", rd, 32'h0);
    bus_read(32'hFFFF_000C, rd);
    chk("post_rst_irq_en", rd, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
